// File: rtl/bram_golden_checker.sv
// Streams NUM_WORDS words from a result BRAM and a golden BRAM and compares them under a bit mask.
// Latency: one word issued per cycle; done pulses in cycle NUM_WORDS+RD_LAT+1 after start on a full run.
// No backpressure: BRAMs are read-only and always ready; start is ignored unless idle.
module bram_golden_checker #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int NUM_WORDS = 294,
  parameter int RD_LAT    = 1,
  parameter int RES_BASE  = 0,
  parameter int GOLD_BASE = 0,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop_first,
  input  logic [DATA_W-1:0]   cmp_mask,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [CNT_W-1:0]    err_count,
  output logic [CNT_W-1:0]    first_idx,
  output logic [DATA_W-1:0]   first_got,
  output logic [DATA_W-1:0]   first_exp,
  output logic [ADDR_W-1:0]   RES_ADDR,
  output logic                RES_EN,
  output logic [DATA_W/8-1:0] RES_WE,
  input  logic [DATA_W-1:0]   RES_DOUT,
  output logic [ADDR_W-1:0]   GOLD_ADDR,
  output logic                GOLD_EN,
  output logic [DATA_W/8-1:0] GOLD_WE,
  input  logic [DATA_W-1:0]   GOLD_DOUT
);

  generate
    if (NUM_WORDS < 1) begin : g_bad_num_words
      $error("bram_golden_checker: NUM_WORDS must be >= 1");
    end
    if (RD_LAT < 1) begin : g_bad_rd_lat
      $error("bram_golden_checker: RD_LAT must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  // Byte distance between consecutive words in either BRAM.
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

  state_t              state;
  state_t              state_nxt;
  logic                issue_en;
  logic                accept;
  logic                stop_q;
  logic [DATA_W-1:0]   mask_q;
  logic [CNT_W-1:0]    issue_idx;
  logic [RD_LAT-1:0]   pipe_vld;
  logic [CNT_W-1:0]    pipe_idx [RD_LAT];
  logic [CNT_W-1:0]    cmp_idx;
  logic                cmp_vld;
  logic                mismatch;
  logic                stop_hit;
  logic                last_issue;
  logic                pipe_empty;
  logic [ADDR_W-1:0]   word_off;

  assign accept     = (state == IDLE) && start;
  assign cmp_vld    = pipe_vld[RD_LAT-1];
  assign cmp_idx    = pipe_idx[RD_LAT-1];
  assign mismatch   = cmp_vld && (((RES_DOUT ^ GOLD_DOUT) & mask_q) != '0);
  assign stop_hit   = mismatch && stop_q;
  assign last_issue = (issue_idx == CNT_W'(NUM_WORDS - 1));
  assign pipe_empty = (pipe_vld == '0);

  // Both BRAMs see the same word offset; address lines idle at zero when not reading.
  assign word_off  = ADDR_W'(issue_idx) * STRIDE;
  assign RES_EN    = issue_en;
  assign GOLD_EN   = issue_en;
  assign RES_ADDR  = issue_en ? (ADDR_W'(RES_BASE) + word_off) : '0;
  assign GOLD_ADDR = issue_en ? (ADDR_W'(GOLD_BASE) + word_off) : '0;
  assign RES_WE    = '0;
  assign GOLD_WE   = '0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-state outputs; a stop hit ends issue even mid-stream.
  always_comb begin
    state_nxt = state;
    issue_en  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        busy     = 1'b1;
        issue_en = 1'b1;
        if (stop_hit || last_issue) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (pipe_empty) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Run configuration is captured once so callers may change the inputs mid-run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stop_q <= 1'b0;
      mask_q <= '0;
    end else if (accept) begin
      stop_q <= stop_first;
      mask_q <= cmp_mask;
    end
  end

  // Word index being issued this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            issue_idx <= '0;
    else if (accept)    issue_idx <= '0;
    else if (issue_en)  issue_idx <= issue_idx + 1'b1;
  end

  // Reads in flight; a stop hit discards everything still travelling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_idx[i] <= '0;
    end else begin
      pipe_vld[0] <= issue_en & ~stop_hit;
      pipe_idx[0] <= issue_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1] & ~stop_hit;
        pipe_idx[i] <= pipe_idx[i-1];
      end
    end
  end

  // Result bookkeeping; err_count==0 doubles as the "no mismatch seen yet" flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
      first_idx <= '0;
      first_got <= '0;
      first_exp <= '0;
      pass      <= 1'b0;
    end else if (accept) begin
      err_count <= '0;
      first_idx <= '0;
      first_got <= '0;
      first_exp <= '0;
      pass      <= 1'b0;
    end else begin
      if (mismatch) begin
        if (err_count != '1) err_count <= err_count + 1'b1;
        if (err_count == '0) begin
          first_idx <= cmp_idx;
          first_got <= RES_DOUT;
          first_exp <= GOLD_DOUT;
        end
      end
      if ((state == DRAIN) && pipe_empty) pass <= (err_count == '0);
    end
  end

endmodule

// File: tb/tb_bram_golden_checker.sv
// Scoreboard bench: two checker instances (RD_LAT 1 and 2) over shared BRAM contents.
// Expected results come from a word-by-word reference model pushed at start.
// Monitors pop and compare on each done pulse.
module tb_bram_golden_checker;

  localparam int NW  = 294;
  localparam logic [31:0] RB1 = 32'h0;
  localparam logic [31:0] GB1 = 32'h0;
  localparam logic [31:0] RB2 = 32'h100;
  localparam logic [31:0] GB2 = 32'h2000;

  typedef struct {
    int          err;
    int          fidx;
    logic [31:0] fgot;
    logic [31:0] fexp;
    bit          pass;
    int          done_rel;
    int          done_cyc;
    int          en;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start1 = 1'b0, start2 = 1'b0;
  logic stop_first = 1'b0;
  logic [31:0] cmp_mask = '1;

  logic busy1, done1, pass1, ren1, gen1;
  logic [15:0] err1, fidx1;
  logic [31:0] fgot1, fexp1, ra1, ga1, rdo1, gdo1;
  logic [3:0] rwe1, gwe1;
  logic busy2, done2, pass2, ren2, gen2;
  logic [15:0] err2, fidx2;
  logic [31:0] fgot2, fexp2, ra2, ga2, rdo2, gdo2;
  logic [3:0] rwe2, gwe2;

  logic [31:0] res_mem [NW];
  logic [31:0] gold_mem [NW];

  int total = 0, bad = 0, cyc = 0;
  int en_c1 = 0, en_c2 = 0, dn1 = 0, dn2 = 0;
  bit ifb1 = 0, ifb2 = 0;
  exp_t q1[$];
  exp_t q2[$];

  bram_golden_checker #(.DATA_W(32), .ADDR_W(32), .NUM_WORDS(NW), .RD_LAT(1),
                        .RES_BASE(0), .GOLD_BASE(0), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .start(start1), .stop_first(stop_first), .cmp_mask(cmp_mask),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_idx(fidx1),
    .first_got(fgot1), .first_exp(fexp1),
    .RES_ADDR(ra1), .RES_EN(ren1), .RES_WE(rwe1), .RES_DOUT(rdo1),
    .GOLD_ADDR(ga1), .GOLD_EN(gen1), .GOLD_WE(gwe1), .GOLD_DOUT(gdo1));

  bram_golden_checker #(.DATA_W(32), .ADDR_W(32), .NUM_WORDS(NW), .RD_LAT(2),
                        .RES_BASE(32'h100), .GOLD_BASE(32'h2000), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .start(start2), .stop_first(stop_first), .cmp_mask(cmp_mask),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .first_idx(fidx2),
    .first_got(fgot2), .first_exp(fexp2),
    .RES_ADDR(ra2), .RES_EN(ren2), .RES_WE(rwe2), .RES_DOUT(rdo2),
    .GOLD_ADDR(ga2), .GOLD_EN(gen2), .GOLD_WE(gwe2), .GOLD_DOUT(gdo2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rd_res(input logic [31:0] a);
    logic [31:0] w = a >> 2;
    if (a[1:0] != 2'b00 || w >= NW) return 32'hBAD0BAD0;
    return res_mem[w];
  endfunction

  function automatic logic [31:0] rd_gold(input logic [31:0] a);
    logic [31:0] w = a >> 2;
    if (a[1:0] != 2'b00 || w >= NW) return 32'hBAD1BAD1;
    return gold_mem[w];
  endfunction

  // BRAM models: 1-cycle for u1, 2-cycle (extra output register) for u2.
  logic [31:0] r1_q, g1_q, r2_a, g2_a, r2_b, g2_b;
  always @(posedge clk) begin
    if (ren1) r1_q <= rd_res(ra1 - RB1);
    if (gen1) g1_q <= rd_gold(ga1 - GB1);
    if (ren2) r2_a <= rd_res(ra2 - RB2);
    if (gen2) g2_a <= rd_gold(ga2 - GB2);
    r2_b <= r2_a;
    g2_b <= g2_a;
  end
  assign rdo1 = r1_q;
  assign gdo1 = g1_q;
  assign rdo2 = r2_b;
  assign gdo2 = g2_b;

  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Reference: walk the words, count masked mismatches, honour stop-at-first.
  function automatic exp_t model(input bit stp, input logic [31:0] msk, input int lat);
    exp_t e;
    int first = -1;
    int err = 0;
    for (int k = 0; k < NW; k++) begin
      if (((res_mem[k] ^ gold_mem[k]) & msk) != 0) begin
        if (first < 0) first = k;
        err++;
        if (stp) break;
      end
    end
    e.err  = (err > 65535) ? 65535 : err;
    e.pass = (err == 0);
    e.fidx = 0; e.fgot = 0; e.fexp = 0;
    if (first >= 0) begin
      e.fidx = first;
      e.fgot = res_mem[first];
      e.fexp = gold_mem[first];
    end
    if (stp && first >= 0) begin
      e.done_rel = first + lat + 2;
      e.en       = (first + lat + 1 < NW) ? first + lat + 1 : NW;
    end else begin
      e.done_rel = NW + lat + 1;
      e.en       = NW;
    end
    e.done_cyc = 0;
    return e;
  endfunction

  function automatic bit if_bad(input logic ren, gen, input logic [31:0] ra, ga,
                                input logic [3:0] rwe, gwe, input logic [31:0] rb, gb);
    if (ren !== gen || rwe !== 4'h0 || gwe !== 4'h0) return 1'b1;
    if (ren) return ((ra - rb) !== (ga - gb));
    return (ra !== 32'h0 || ga !== 32'h0);
  endfunction

  task automatic check_run(input string t, input exp_t e, input int enc, input bit ifb,
                           input logic [15:0] err, fidx, input logic [31:0] fg, fe, input logic ps);
    cmp({t, "_done_cycle"}, 64'(cyc), 64'(e.done_cyc));
    cmp({t, "_err_count"}, 64'(err), 64'(e.err));
    cmp({t, "_first_idx"}, 64'(fidx), 64'(e.fidx));
    cmp({t, "_first_got"}, 64'(fg), 64'(e.fgot));
    cmp({t, "_first_exp"}, 64'(fe), 64'(e.fexp));
    cmp({t, "_pass"}, 64'(ps), 64'(e.pass));
    cmp({t, "_en_cycles"}, 64'(enc), 64'(e.en));
    cmp({t, "_bram_if_ok"}, 64'(ifb), 64'(0));
  endtask

  // Monitors: tally enable cycles / interface sanity, pop and compare on done.
  always @(negedge clk) begin
    if (rst) begin
      en_c1 = 0; ifb1 = 0;
    end else begin
      if (ren1) en_c1++;
      if (if_bad(ren1, gen1, ra1, ga1, rwe1, gwe1, RB1, GB1)) ifb1 = 1;
      if (done1) begin
        dn1++;
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL u1_spurious_done: got done=1 want no pending run (t=%0t)", $time);
        end else begin
          check_run("u1", q1.pop_front(), en_c1, ifb1, err1, fidx1, fgot1, fexp1, pass1);
        end
        en_c1 = 0; ifb1 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      en_c2 = 0; ifb2 = 0;
    end else begin
      if (ren2) en_c2++;
      if (if_bad(ren2, gen2, ra2, ga2, rwe2, gwe2, RB2, GB2)) ifb2 = 1;
      if (done2) begin
        dn2++;
        if (q2.size() == 0) begin
          total++; bad++;
          $display("FAIL u2_spurious_done: got done=1 want no pending run (t=%0t)", $time);
        end else begin
          check_run("u2", q2.pop_front(), en_c2, ifb2, err2, fidx2, fgot2, fexp2, pass2);
        end
        en_c2 = 0; ifb2 = 0;
      end
    end
  end

  function automatic int qs(input int inst);
    return (inst == 1) ? q1.size() : q2.size();
  endfunction

  task automatic fill_equal();
    for (int k = 0; k < NW; k++) begin
      gold_mem[k] = $urandom;
      res_mem[k]  = gold_mem[k];
    end
  endtask

  // Launch one run; poke>0 re-pulses start that many cycles in (must be ignored).
  task automatic run(input int inst, input bit stp, input logic [31:0] msk, input int poke);
    exp_t e;
    e = model(stp, msk, (inst == 1) ? 1 : 2);
    @(negedge clk);
    stop_first = stp;
    cmp_mask   = msk;
    if (inst == 1) start1 = 1'b1; else start2 = 1'b1;
    @(posedge clk);
    #1;
    e.done_cyc = cyc + e.done_rel;
    if (inst == 1) q1.push_back(e); else q2.push_back(e);
    cmp("busy_after_start", 64'((inst == 1) ? busy1 : busy2), 64'(1));
    @(negedge clk);
    start1 = 1'b0; start2 = 1'b0;
    stop_first = ~stp;
    cmp_mask   = $urandom;
    if (poke > 0) begin
      repeat (poke) @(negedge clk);
      if (inst == 1) start1 = 1'b1; else start2 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; start2 = 1'b0;
    end
    for (int i = 0; i < 1000 && qs(inst) != 0; i++) @(negedge clk);
    if (qs(inst) != 0) begin
      total++; bad++;
      $display("FAIL run_timeout: got no done within 1000 cycles want done (inst %0d)", inst);
      if (inst == 1) q1.delete(); else q2.delete();
    end
  endtask

  task automatic zchk(input string t, input logic [4:0] fl, input logic [31:0] cnt,
                      input logic [31:0] g, e, input logic [63:0] ad, input logic [7:0] we);
    cmp({t, "_flags_zero"}, 64'(fl), 64'(0));
    cmp({t, "_counts_zero"}, 64'(cnt), 64'(0));
    cmp({t, "_first_got_zero"}, 64'(g), 64'(0));
    cmp({t, "_first_exp_zero"}, 64'(e), 64'(0));
    cmp({t, "_addr_zero"}, ad, 64'(0));
    cmp({t, "_we_zero"}, 64'(we), 64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    fill_equal();
    #2 rst = 1'b1;
    #1;
    zchk("rst_u1", {busy1, done1, pass1, ren1, gen1}, {err1, fidx1}, fgot1, fexp1, {ra1, ga1}, {rwe1, gwe1});
    zchk("rst_u2", {busy2, done2, pass2, ren2, gen2}, {err2, fidx2}, fgot2, fexp2, {ra2, ga2}, {rwe2, gwe2});
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: identical contents, full compare.
    run(1, 1'b0, '1, 0);
    // 2: two mismatching words, first one with known values.
    res_mem[7] = 32'hDEADBEEF; gold_mem[7] = 32'h00000012;
    res_mem[200] = gold_mem[200] ^ 32'h8000_0000;
    run(1, 1'b0, '1, 0);
    // 3: difference only in masked-off bits.
    fill_equal();
    res_mem[5] = gold_mem[5] ^ 32'h0000_A5A5;
    run(1, 1'b0, 32'hFFFF_0000, 0);
    // 4: stop at first mismatch.
    fill_equal();
    res_mem[10] = gold_mem[10] ^ 32'h1;
    res_mem[20] = gold_mem[20] ^ 32'h10;
    run(1, 1'b1, '1, 0);
    // 5: two-cycle BRAM instance, mismatch at word 0.
    fill_equal();
    res_mem[0] = gold_mem[0] ^ 32'h4;
    run(2, 1'b0, '1, 0);

    // 6: reset while word 100 is issuing.
    fill_equal();
    d0 = dn1;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    repeat (100) @(negedge clk);
    cmp("addr_at_word100", 64'(ra1), 64'(400));
    rst = 1'b1;
    #1;
    zchk("midrun_rst", {busy1, done1, pass1, ren1, gen1}, {err1, fidx1}, fgot1, fexp1, {ra1, ga1}, {rwe1, gwe1});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    cmp("no_done_after_rst", 64'(dn1 - d0), 64'(0));
    // Re-start passes; a start pulsed mid-run is ignored.
    run(1, 1'b0, '1, 50);
    run(2, 1'b1, '1, 30);

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      int inst;
      int nmis;
      logic [31:0] msk;
      inst = 1 + int'($urandom % 2);
      fill_equal();
      nmis = int'($urandom % 5);
      for (int m = 0; m < nmis; m++) begin
        int idx;
        idx = int'($urandom % NW);
        res_mem[idx] = res_mem[idx] ^ (32'h1 << ($urandom % 32));
      end
      msk = ($urandom % 2) ? 32'hFFFF_FFFF : $urandom;
      run(inst, 1'($urandom % 2), msk, 0);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
